// File: rtl/biss_poll_ctrl.sv
// BiSS-C polling controller: issues periodic or on-demand frame requests to a
// BiSS master, applies CRC retries, a response timeout and a line recovery gap.
module biss_poll_ctrl #(
  parameter int POLL_PERIOD = 50000,
  parameter int TIMEOUT     = 5000,
  parameter int MAX_RETRY   = 3,
  parameter int RECOVER_CYC = 1000,
  parameter int POS_W       = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             req,
  output logic             start,
  input  logic             m_done,
  input  logic [POS_W-1:0] m_pos,
  input  logic             m_err,
  input  logic             m_warn,
  input  logic             m_crc_ok,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  output logic             err_flag,
  output logic             warn_flag,
  output logic             fail,
  output logic [7:0]       crc_err_cnt,
  output logic [7:0]       timeout_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int PW      = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int CNT_MAX = (TIMEOUT > RECOVER_CYC) ? TIMEOUT : RECOVER_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRY + 2);

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] REC_LAST  = CW'(RECOVER_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      timer_q, timer_d;
  logic               pending_q, pending_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic               retry_pend_q, retry_pend_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               err_q, err_d;
  logic               warn_q, warn_d;
  logic               pos_valid_q, pos_valid_d;
  logic               fail_q, fail_d;
  logic [7:0]         crc_cnt_q, crc_cnt_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               tick;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    retry_pend_d = retry_pend_q;
    pos_d        = pos_q;
    err_d        = err_q;
    warn_d       = warn_q;
    crc_cnt_d    = crc_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    pos_valid_d  = 1'b0;
    fail_d       = 1'b0;
    tick         = 1'b0;

    if (!enable) begin
      timer_d = '0;
    end else if (timer_q == POLL_LAST) begin
      timer_d = '0;
      tick    = 1'b1;
    end else begin
      timer_d = timer_q + PW'(1);
    end

    // Ticks and requests merge into a single pending flag, which only IDLE consumes.
    pending_d = pending_q | tick | req;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d      = S_ISSUE;
          pending_d    = 1'b0;
          retry_d      = '0;
          retry_pend_d = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d      = S_WAIT;
        cnt_d        = '0;
        retry_pend_d = 1'b0;
      end
      S_WAIT: begin
        // A frame completing on the expiry cycle still counts as done.
        if (m_done) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
          if (m_crc_ok) begin
            pos_d       = m_pos;
            err_d       = m_err;
            warn_d      = m_warn;
            pos_valid_d = 1'b1;
          end else begin
            if (crc_cnt_q != 8'hFF) crc_cnt_d = crc_cnt_q + 8'd1;
            retry_d = retry_q + RW'(1);
            if (retry_q >= RETRY_MAX) fail_d = 1'b1;
            else retry_pend_d = 1'b1;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
          fail_d  = 1'b1;
          if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_q == REC_LAST) begin
          state_d = retry_pend_q ? S_ISSUE : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
      pos_q        <= '0;
      err_q        <= 1'b0;
      warn_q       <= 1'b0;
      pos_valid_q  <= 1'b0;
      fail_q       <= 1'b0;
      crc_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      retry_pend_q <= retry_pend_d;
      pos_q        <= pos_d;
      err_q        <= err_d;
      warn_q       <= warn_d;
      pos_valid_q  <= pos_valid_d;
      fail_q       <= fail_d;
      crc_cnt_q    <= crc_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
    end
  end

  assign start       = start_q;
  assign pos         = pos_q;
  assign pos_valid   = pos_valid_q;
  assign err_flag    = err_q;
  assign warn_flag   = warn_q;
  assign fail        = fail_q;
  assign crc_err_cnt = crc_cnt_q;
  assign timeout_cnt = tmo_cnt_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_biss_poll_ctrl.sv
// Bench for biss_poll_ctrl: a BiSS master model answers each start pulse, and a
// transaction-level model predicts start/pos_valid/fail cycles and counters.
module tb_biss_poll_ctrl;

  localparam int POLL_PERIOD = 100;
  localparam int TIMEOUT     = 40;
  localparam int MAX_RETRY   = 2;
  localparam int RECOVER_CYC = 10;
  localparam int POS_W       = 26;
  localparam int EW          = 62;

  logic             clk, rst, enable, req, start, m_done, m_err, m_warn, m_crc_ok;
  logic [POS_W-1:0] m_pos, pos;
  logic             pos_valid, err_flag, warn_flag, fail, busy;
  logic [7:0]       crc_err_cnt, timeout_cnt;
  logic [1:0]       dbg_state;

  biss_poll_ctrl #(
    .POLL_PERIOD(POLL_PERIOD), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY),
    .RECOVER_CYC(RECOVER_CYC), .POS_W(POS_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .start(start),
    .m_done(m_done), .m_pos(m_pos), .m_err(m_err), .m_warn(m_warn),
    .m_crc_ok(m_crc_ok), .pos(pos), .pos_valid(pos_valid), .err_flag(err_flag),
    .warn_flag(warn_flag), .fail(fail), .crc_err_cnt(crc_err_cnt),
    .timeout_cnt(timeout_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  int done_at = -1;
  int n_tests = 0;
  int n_fail = 0;
  int exp_crc = 0;
  int exp_tmo = 0;
  // response word: [36:29] delay (0 = never answer), [28] crc_ok, [27] err, [26] warn, [25:0] pos
  logic [36:0]   plan_q[$];
  logic [36:0]   rq[$];
  logic [36:0]   cur_resp;
  logic [EW-1:0] obs_q[$];
  logic [EW-1:0] exp_q[$];

  // event word: {kind, cycle, {err, warn, pos}}; kind 0 = start, 1 = pos_valid, 2 = fail
  function automatic logic [EW-1:0] ev(input int kind, input int c, input logic [27:0] d);
    return {kind[1:0], c[31:0], d};
  endfunction

  function automatic logic [36:0] resp(input int d, input logic ok, input logic e,
                                       input logic w, input logic [25:0] p);
    return {d[7:0], ok, e, w, p};
  endfunction

  // one clock: record DUT events of the new cycle, then play the master
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (fail)      obs_q.push_back(ev(2, cyc, 28'd0));
    if (pos_valid) obs_q.push_back(ev(1, cyc, {err_flag, warn_flag, pos}));
    if (start)     obs_q.push_back(ev(0, cyc, 28'd0));
    m_done   = 1'b0;
    m_crc_ok = 1'($urandom_range(0, 1));
    m_err    = 1'($urandom_range(0, 1));
    m_warn   = 1'($urandom_range(0, 1));
    m_pos    = POS_W'($urandom);
    if (done_at == cyc) begin
      m_done = 1'b1;
      {m_crc_ok, m_err, m_warn, m_pos} = cur_resp[28:0];
    end
    if (start) begin
      done_at = -1;
      if (rq.size() > 0) begin
        cur_resp = rq.pop_front();
        if (cur_resp[36:29] != 8'd0) done_at = cyc + int'(cur_resp[36:29]);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_req();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  // Reference model: one request whose pending flag is seen at cycle r, served
  // by the responses in plan_q. Start r+2, outcome d+1 after start, recovery gap.
  task automatic model(input int r, output int idle_at);
    int s, o, retries;
    int d;
    logic [36:0] x;
    s = r + 2;
    retries = 0;
    idle_at = s;
    while (plan_q.size() > 0) begin
      x = plan_q.pop_front();
      rq.push_back(x);
      d = int'(x[36:29]);
      exp_q.push_back(ev(0, s, 28'd0));
      if (d != 0 && d <= TIMEOUT) begin
        o = s + d + 1;
        if (x[28]) begin
          exp_q.push_back(ev(1, o, x[27:0]));
          idle_at = o + RECOVER_CYC;
          break;
        end
        if (exp_crc < 255) exp_crc++;
        retries++;
        if (retries > MAX_RETRY) begin
          exp_q.push_back(ev(2, o, 28'd0));
          idle_at = o + RECOVER_CYC;
          break;
        end
        s = o + RECOVER_CYC;
      end else begin
        o = s + TIMEOUT + 1;
        exp_q.push_back(ev(2, o, 28'd0));
        if (exp_tmo < 255) exp_tmo++;
        idle_at = o + RECOVER_CYC;
        break;
      end
    end
    plan_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    run(3);
    n_tests++;
    if ({start, pos_valid, fail, busy, err_flag, warn_flag} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 000000",
               {start, pos_valid, fail, busy, err_flag, warn_flag});
    end
    n_tests++;
    if ({pos, crc_err_cnt, timeout_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got pos=%h crc=%0d tmo=%0d expected 0", pos, crc_err_cnt, timeout_cnt);
    end
    n_tests++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    rst = 1'b1;
    run(3);
    obs_q.delete();
  endtask

  task automatic test_periodic();
    int e;
    obs_q.delete();
    exp_q.delete();
    rq.push_back(resp(30, 1'b1, 1'b0, 1'b0, 26'h2B5A6D9));
    rq.push_back(resp(30, 1'b1, 1'b1, 1'b0, 26'h2B5A6D9));
    rq.push_back(resp(30, 1'b1, 1'b0, 1'b1, 26'h2B5A6D9));
    e = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ev(0, e + 101 + 100 * k, 28'd0));
      exp_q.push_back(ev(1, e + 132 + 100 * k, {k == 1, k == 2, 26'h2B5A6D9}));
    end
    enable = 1'b1;
    run(350);
    enable = 1'b0;
    run(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL periodic_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL periodic_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if ({pos, err_flag, warn_flag, busy} !== {26'h2B5A6D9, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL periodic_final: got pos=%h err=%b warn=%b busy=%b expected 2b5a6d9 0 1 0",
               pos, err_flag, warn_flag, busy);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // crc_ok pattern given as bits, oldest first in bit 0
  task automatic test_crc(input string name, input int n_frames, input logic [2:0] ok_bits);
    int idle;
    logic [25:0] p;
    obs_q.delete();
    exp_q.delete();
    p = 26'($urandom);
    for (int k = 0; k < n_frames; k++)
      plan_q.push_back(resp(5 + k, ok_bits[k], 1'b1, 1'b0, p));
    model(cyc, idle);
    do_req();
    while (cyc < idle + 2) step();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_events: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_event[%0d]: got %h expected %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (crc_err_cnt !== 8'(exp_crc)) begin
      n_fail++;
      $display("FAIL %s_crc_cnt: got %0d expected %0d", name, crc_err_cnt, exp_crc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout(input string name, input int d);
    int idle;
    obs_q.delete();
    exp_q.delete();
    plan_q.push_back(resp(d, 1'b1, 1'b0, 1'b1, 26'($urandom)));
    model(cyc, idle);
    do_req();
    while (cyc < idle - 1) step();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy_last: got %b expected 1", name, busy);
    end
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_idle: got %b expected 0", name, busy);
    end
    run(2);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_events: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_event[%0d]: got %h expected %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (timeout_cnt !== 8'(exp_tmo)) begin
      n_fail++;
      $display("FAIL %s_tmo_cnt: got %0d expected %0d", name, timeout_cnt, exp_tmo);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int e, idle1, idle2;
    obs_q.delete();
    exp_q.delete();
    e = cyc;
    plan_q.push_back(resp(20, 1'b1, 1'b0, 1'b0, 26'($urandom)));
    model(e + 99, idle1);
    plan_q.push_back(resp(12, 1'b1, 1'b1, 1'b1, 26'($urandom)));
    model(idle1 - 1, idle2);
    enable = 1'b1;
    run(99);
    req = 1'b1;
    step();
    req = 1'b0;
    enable = 1'b0;
    run(5);
    req = 1'b1;
    step();
    req = 1'b0;
    while (cyc < idle2 + 2) step();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_events: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_wait();
    int s;
    obs_q.delete();
    rq.push_back(resp(30, 1'b1, 1'b1, 1'b1, 26'h3FFFFFF));
    do_req();
    s = cyc + 1;
    while (cyc < s + 10) step();
    #5 rst = 1'b0;
    #1;
    n_tests++;
    if ({start, pos_valid, fail, busy, err_flag, warn_flag, dbg_state} !== 8'b0) begin
      n_fail++;
      $display("FAIL rst_async: got %b expected 00000000",
               {start, pos_valid, fail, busy, err_flag, warn_flag, dbg_state});
    end
    exp_crc = 0;
    exp_tmo = 0;
    run(3);
    rst = 1'b1;
    while (cyc < s + 35) step();
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== ev(0, s, 28'd0)) begin
      n_fail++;
      $display("FAIL rst_events: got %0d events expected only start at %0d", obs_q.size(), s);
    end
    n_tests++;
    if ({pos, crc_err_cnt, timeout_cnt, busy, dbg_state, err_flag, warn_flag} !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs: got pos=%h crc=%0d tmo=%0d busy=%b st=%0d expected 0",
               pos, crc_err_cnt, timeout_cnt, busy, dbg_state);
    end
    rq.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    int idle, d;
    obs_q.delete();
    exp_q.delete();
    for (int t = 0; t < 30; t++) begin
      for (int a = 0; a <= MAX_RETRY; a++) begin
        d = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 50);
        plan_q.push_back(resp(d, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 26'($urandom)));
      end
      model(cyc, idle);
      do_req();
      while (cyc < idle + $urandom_range(0, 4)) step();
    end
    run(2);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_events: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if ({crc_err_cnt, timeout_cnt} !== {8'(exp_crc), 8'(exp_tmo)}) begin
      n_fail++;
      $display("FAIL random_counters: got crc=%0d tmo=%0d expected crc=%0d tmo=%0d",
               crc_err_cnt, timeout_cnt, exp_crc, exp_tmo);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation();
    int idle;
    for (int t = 0; t < 90; t++) begin
      for (int a = 0; a <= MAX_RETRY; a++) plan_q.push_back(resp(1, 1'b0, 1'b0, 1'b0, 26'd0));
      model(cyc, idle);
      do_req();
      while (cyc < idle) step();
    end
    for (int t = 0; t < 258; t++) begin
      plan_q.push_back(resp(0, 1'b0, 1'b0, 1'b0, 26'd0));
      model(cyc, idle);
      do_req();
      while (cyc < idle) step();
    end
    run(2);
    n_tests++;
    if (crc_err_cnt !== 8'd255 || exp_crc != 255) begin
      n_fail++;
      $display("FAIL sat_crc: got %0d expected 255", crc_err_cnt);
    end
    n_tests++;
    if (timeout_cnt !== 8'd255 || exp_tmo != 255) begin
      n_fail++;
      $display("FAIL sat_tmo: got %0d expected 255", timeout_cnt);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    req = 1'b0;
    m_done = 1'b0;
    m_err = 1'b0;
    m_warn = 1'b0;
    m_crc_ok = 1'b0;
    m_pos = '0;
    test_reset();
    test_periodic();
    test_crc("crc_all_bad", 3, 3'b000);
    test_crc("crc_then_ok", 2, 3'b010);
    test_timeout("timeout", 0);
    test_timeout("done_at_limit", TIMEOUT);
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/biss_poll_ctrl.md
BISS_POLL_CTRL -- requirements
Module: biss_poll_ctrl

Interface
REQ-001 Parameter POLL_PERIOD, default 50000, poll interval in clk cycles (1 ms at 50 MHz).
REQ-002 Parameter TIMEOUT, default 5000, maximum cycles from start pulse to m_done.
REQ-003 Parameter MAX_RETRY, default 3, CRC-failure retries per request before fail.
REQ-004 Parameter RECOVER_CYC, default 1000, idle gap after every transaction (20 us BiSS timeout recovery).
REQ-005 Parameter POS_W, default 26, position width.
REQ-006 clk  in  1  system clock, 50 MHz.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 enable  in  1  periodic polling enable.
REQ-009 req  in  1  one-shot read request, honoured regardless of enable.
REQ-010 start  out  1  one-cycle pulse telling the BiSS master to run one frame.
REQ-011 m_done  in  1  one-cycle pulse from master: frame complete.
REQ-012 m_pos  in  POS_W  decoded position, valid with m_done.
REQ-013 m_err, m_warn  in  1 each  decoded error/warning bits, active-high, valid with m_done.
REQ-014 m_crc_ok  in  1  CRC-6 check result, valid with m_done.
REQ-015 pos  out  POS_W  last good position.
REQ-016 pos_valid  out  1  one-cycle pulse, pos/err_flag/warn_flag updated.
REQ-017 err_flag, warn_flag  out  1 each  m_err/m_warn of last good frame.
REQ-018 fail  out  1  one-cycle pulse, request abandoned.
REQ-019 crc_err_cnt, timeout_cnt  out  8 each  saturating event counters.
REQ-020 busy  out  1  high in any state except IDLE.

Function
REQ-021 States SHALL be IDLE, ISSUE, WAIT, RECOVER; one-hot or binary is free.
REQ-022 Poll timer SHALL count 0..POLL_PERIOD-1 while enable=1, wrap to 0 and set pending on wrap; held at 0 while enable=0.
REQ-023 req=1 SHALL set pending; tick and req in the same cycle, or while pending is already set, SHALL coalesce into one pending.
REQ-024 IDLE with pending=1 SHALL go to ISSUE next cycle and clear pending; retry counter cleared.
REQ-025 ISSUE SHALL last exactly one cycle with start=1, then go to WAIT with timeout counter at 0.
REQ-026 WAIT with m_done=1 and m_crc_ok=1: next edge SHALL load pos, err_flag, warn_flag, pulse pos_valid for one cycle, enter RECOVER.
REQ-027 WAIT with m_done=1 and m_crc_ok=0: crc_err_cnt +1 (saturate at 255), retry +1; if retry now exceeds MAX_RETRY, pulse fail, else mark retry pending; enter RECOVER.
REQ-028 WAIT with TIMEOUT cycles elapsed and no m_done: timeout_cnt +1 (saturate), pulse fail, enter RECOVER; no retry on timeout.
REQ-029 m_done in the same cycle as timeout expiry SHALL be treated as done, not timeout.
REQ-030 m_done outside WAIT SHALL be ignored.
REQ-031 RECOVER SHALL last RECOVER_CYC cycles, then go to ISSUE if retry pending, else IDLE.
REQ-032 Requests arriving while busy SHALL stay pending and be served after RECOVER.
REQ-033 Latency: pending set in IDLE at cycle N gives start=1 at N+1; m_done at cycle D gives pos_valid/fail at D+1.
REQ-034 enable deasserted mid-transaction SHALL not abort it.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, clear pending, timers, retry count, counters, pos, flags; start, pos_valid, fail, busy=0.
REQ-036 Reset mid-WAIT SHALL drop the transaction; later m_done SHALL be ignored.

Verification (POLL_PERIOD=100, TIMEOUT=40, MAX_RETRY=2, RECOVER_CYC=10, POS_W=26)
REQ-037 enable=1, master returns m_done 30 cycles after start, m_crc_ok=1, m_pos=0x2B5A6D9 -> start every 100 cycles, pos=0x2B5A6D9, pos_valid one cycle after m_done.
REQ-038 req pulse, m_crc_ok=0 on every frame -> three start pulses each 10 cycles after the preceding RECOVER entry, crc_err_cnt=3, single fail pulse, no pos_valid.
REQ-039 req, m_crc_ok=0 then 1 -> two start pulses, crc_err_cnt=1, pos_valid once, no fail.
REQ-040 req, no m_done -> fail 41 cycles after start, timeout_cnt=1, busy low 10 cycles later; m_done at 40 cycles instead -> pos_valid, timeout_cnt unchanged.
REQ-041 req and poll tick in the same cycle while IDLE -> exactly one start; req during WAIT -> second start after RECOVER.
REQ-042 rst low mid-WAIT, then m_done -> all outputs 0, no pos_valid, state IDLE.
